elevator_multi_ctrl: RTL

//  Parametrised multi-floor elevator controller. Latches floor calls, serves them in

---
 rtl/elevator_multi_ctrl_if.sv | 32 +++
 rtl/elevator_multi_ctrl.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/elevator_multi_ctrl_if.sv
// Elevator controller signal bundle.
//   CallReq   : floor call bits from the call panels (level or pulse)
//   DoorBlock : door obstruction sensor
//   Floor     : current floor
//   MotorEn   : motor running
//   Dir       : travel direction, 1 = up, 0 = down
//   DoorAnim  : door thermometer, 0 = fully open, all ones = fully closed
//   Pending   : latched outstanding calls
// The master modport is the panel/datapath side; the slave modport is the controller.
interface elevator_multi_ctrl_if #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int DOOR_STEPS = 4
);
  logic [FLOORS-1:0]     CallReq;
  logic                  DoorBlock;
  logic [FLOOR_W-1:0]    Floor;
  logic                  MotorEn;
  logic                  Dir;
  logic [DOOR_STEPS-1:0] DoorAnim;
  logic [FLOORS-1:0]     Pending;

  modport master (
    output CallReq, DoorBlock,
    input  Floor, MotorEn, Dir, DoorAnim, Pending
  );

  modport slave (
    input  CallReq, DoorBlock,
    output Floor, MotorEn, Dir, DoorAnim, Pending
  );
endinterface

// File: rtl/elevator_multi_ctrl.sv
// Multi-floor elevator controller. Latches floor calls, serves them in collective
// (SCAN) order and sequences door closing, travel, door opening and dwell.
// Ports:
//   CLK   : system clock
//   RST_n : asynchronous active-low reset
//   bus   : elevator_multi_ctrl_if.slave (calls and obstruction in; floor, motor,
//           direction, door animation and pending calls out, all registered)
//
// state      | meaning
// -----------+------------------------------------------------------------
// ST_IDLE    | doors open, no work outside the current floor
// ST_CLOSING | door animation filling towards fully closed
// ST_MOVING  | motor on, stepping one floor every TRAVEL cycles
// ST_OPENING | door animation draining towards fully open
// ST_DWELL   | doors fully open, counting down before auto-close
module elevator_multi_ctrl #(
  parameter int FLOORS     = 4,
  parameter int FLOOR_W    = 2,
  parameter int DOOR_STEPS = 4,
  parameter int TRAVEL     = 2,
  parameter int DWELL      = 3
) (
  input logic                  CLK,
  input logic                  RST_n,
  elevator_multi_ctrl_if.slave bus
);
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_CLOSING = 3'd1;
  localparam logic [2:0] ST_MOVING  = 3'd2;
  localparam logic [2:0] ST_OPENING = 3'd3;
  localparam logic [2:0] ST_DWELL   = 3'd4;

  localparam int TRV_W = (TRAVEL > 1) ? $clog2(TRAVEL) : 1;
  localparam int DWL_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [TRV_W-1:0]   TRV_LAST  = TRV_W'(TRAVEL - 1);
  localparam logic [DWL_W-1:0]   DWL_LOAD  = DWL_W'(DWELL - 1);
  localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);

  logic [2:0]            state_q, state_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  motor_q, motor_d;
  logic                  dir_q, dir_d;
  logic [DOOR_STEPS-1:0] door_q, door_d;
  logic [FLOORS-1:0]     pend_q, pend_d;
  logic [TRV_W-1:0]      travel_q, travel_d;
  logic [DWL_W-1:0]      dwell_q, dwell_d;

  logic [FLOORS-1:0]  floor_mask, nxt_mask, pend_nx;
  logic [FLOOR_W-1:0] floor_nx;
  logic               here_call;

  // True when any call bit lies strictly above (up=1) or below (up=0) floor f.
  function automatic logic any_beyond(input logic [FLOORS-1:0] p,
                                      input logic [FLOOR_W-1:0] f,
                                      input logic up);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (up ? (i > int'(f)) : (i < int'(f))) hit = hit | p[i];
    end
    return hit;
  endfunction

  always_comb begin
    state_d  = state_q;
    floor_d  = floor_q;
    motor_d  = motor_q;
    dir_d    = dir_q;
    door_d   = door_q;
    travel_d = travel_q;
    dwell_d  = dwell_q;
    floor_nx = floor_q;
    nxt_mask = '0;

    floor_mask = FLOORS'(1) << floor_q;
    here_call  = |(bus.CallReq & floor_mask);
    // A call for the floor we are standing at is only latched while the doors are
    // sealed for travel; otherwise it is answered by the open doors themselves.
    pend_nx = pend_q | (bus.CallReq & ((state_q == ST_MOVING) ? '1 : ~floor_mask));
    pend_d  = pend_nx;

    case (state_q)
      ST_IDLE: begin
        if (|((pend_q | bus.CallReq) & ~floor_mask)) state_d = ST_CLOSING;
      end
      ST_CLOSING: begin
        // Obstruction or a hall call here wins even over a fully closed door.
        if (bus.DoorBlock || here_call) begin
          state_d = ST_OPENING;
          door_d  = door_q >> 1;
        end else if (&door_q) begin
          state_d  = ST_MOVING;
          motor_d  = 1'b1;
          travel_d = '0;
          if (!any_beyond(pend_nx, floor_q, dir_q)) dir_d = ~dir_q;
        end else begin
          door_d = (door_q << 1) | DOOR_STEPS'(1);
        end
      end
      ST_MOVING: begin
        if (travel_q == TRV_LAST) begin
          travel_d = '0;
          if (dir_q && floor_q != FLOOR_TOP)         floor_nx = floor_q + 1'b1;
          else if (!dir_q && floor_q != '0)          floor_nx = floor_q - 1'b1;
          floor_d  = floor_nx;
          nxt_mask = FLOORS'(1) << floor_nx;
          if (|(pend_nx & nxt_mask) || !any_beyond(pend_nx, floor_nx, dir_q)) begin
            motor_d = 1'b0;
            pend_d  = pend_nx & ~nxt_mask;
            state_d = ST_OPENING;
          end
        end else begin
          travel_d = travel_q + 1'b1;
        end
      end
      ST_OPENING: begin
        door_d = door_q >> 1;
        if (door_q == '0) begin
          state_d = ST_DWELL;
          dwell_d = DWL_LOAD;
        end
      end
      ST_DWELL: begin
        if (bus.DoorBlock || here_call) begin
          dwell_d = DWL_LOAD;
        end else if (dwell_q == '0) begin
          state_d = (|pend_nx) ? ST_CLOSING : ST_IDLE;
        end else begin
          dwell_d = dwell_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        motor_d = 1'b0;
        door_d  = '0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q  <= ST_IDLE;
      floor_q  <= '0;
      motor_q  <= 1'b0;
      dir_q    <= 1'b1;
      door_q   <= '0;
      pend_q   <= '0;
      travel_q <= '0;
      dwell_q  <= '0;
    end else begin
      state_q  <= state_d;
      floor_q  <= floor_d;
      motor_q  <= motor_d;
      dir_q    <= dir_d;
      door_q   <= door_d;
      pend_q   <= pend_d;
      travel_q <= travel_d;
      dwell_q  <= dwell_d;
    end
  end

  assign bus.Floor    = floor_q;
  assign bus.MotorEn  = motor_q;
  assign bus.Dir      = dir_q;
  assign bus.DoorAnim = door_q;
  assign bus.Pending  = pend_q;
endmodule
